// File: rtl/rast_pkg.sv
// Shared rasterizer definitions.
// Holds the scheduler FSM state type, the one-hot subsample pitch codes,
// the helper that turns a pitch code into a grid step, and a point type.
package rast_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_e;

  // One-hot subsample pitch codes (samples per pixel edge: 1, 2, 4, 8)
  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  localparam int PT_SIGFIG = 24;

  typedef struct packed {
    logic signed [PT_SIGFIG-1:0] y;
    logic signed [PT_SIGFIG-1:0] x;
  } point_t;

  // Grid step in fixed point. Anything that is not a legal one-hot code
  // falls back to whole-pixel stepping.
  function automatic logic [31:0] step_of(input logic [3:0] ss, input int unsigned radix);
    case (ss)
      SS_4X:   step_of = 32'd1 << (radix - 1);
      SS_16X:  step_of = 32'd1 << (radix - 2);
      SS_64X:  step_of = 32'd1 << (radix - 3);
      default: step_of = 32'd1 << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Bus bundle between bounding-box generation, the sample scheduler and the
// sample-test datapath.
//   slave  : scheduler side (takes triangle/box, drives held triangle + sample)
//   master : surrounding pipeline side
interface sample_scheduler_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  import rast_pkg::*;

  // upstream triangle offer
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R14S;   // [0]=ll (x,y), [1]=ur (x,y)
  logic                                   validTri_R14H;
  logic                                   readyTri_R14H;
  // static configuration and downstream stall
  logic [3:0]                             subSample_RnnnnU;
  logic                                   halt_RnnnnH;
  // downstream sample stream
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R16U;
  logic [1:0][SIGFIG-1:0]                 sample_R16S; // [0]=x, [1]=y
  logic                                   validSamp_R16H;

  modport slave (
    input  tri_R14S, color_R14U, box_R14S, validTri_R14H,
    input  subSample_RnnnnU, halt_RnnnnH,
    output readyTri_R14H,
    output tri_R16S, color_R16U, sample_R16S, validSamp_R16H
  );

  modport master (
    output tri_R14S, color_R14U, box_R14S, validTri_R14H,
    output subSample_RnnnnU, halt_RnnnnH,
    input  readyTri_R14H,
    input  tri_R16S, color_R16U, sample_R16S, validSamp_R16H
  );

endinterface

// File: rtl/sample_step.sv
// Next raster position for the sample walk.
// Inputs: current sample (x,y), snapped lower-left x, upper-right (x,y), step.
// Outputs: next sample (x,y) and last, set when the current sample is the
// final one in the box (next position then just echoes the current one).
// Sums are one bit wider than the coordinates so a box edge near the
// largest positive coordinate cannot wrap to a negative position.
module sample_step #(
  parameter int SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] samp_x,
  input  logic signed [SIGFIG-1:0] samp_y,
  input  logic signed [SIGFIG-1:0] ll_x,
  input  logic signed [SIGFIG-1:0] ur_x,
  input  logic signed [SIGFIG-1:0] ur_y,
  input  logic signed [SIGFIG-1:0] step,
  output logic signed [SIGFIG-1:0] nxt_x,
  output logic signed [SIGFIG-1:0] nxt_y,
  output logic                     last
);

  logic signed [SIGFIG:0] sum_x, sum_y, ur_x_e, ur_y_e;

  assign sum_x  = {samp_x[SIGFIG-1], samp_x} + {step[SIGFIG-1], step};
  assign sum_y  = {samp_y[SIGFIG-1], samp_y} + {step[SIGFIG-1], step};
  assign ur_x_e = {ur_x[SIGFIG-1], ur_x};
  assign ur_y_e = {ur_y[SIGFIG-1], ur_y};

  always_comb begin
    nxt_x = samp_x;
    nxt_y = samp_y;
    last  = 1'b0;
    if (sum_x <= ur_x_e) begin
      nxt_x = sum_x[SIGFIG-1:0];
    end else if (sum_y <= ur_y_e) begin
      nxt_x = ll_x;
      nxt_y = sum_y[SIGFIG-1:0];
    end else begin
      last = 1'b1;
    end
  end

endmodule

// File: rtl/sample_scheduler.sv
// Sample scheduler: accepts one triangle + bounding box at a time and walks
// every grid sample inside the box in raster order, one candidate per cycle,
// alongside the held triangle and color. Downstream halt freezes everything.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sample_scheduler_if.slave (triangle offer, pitch, halt,
//              held triangle/color, sample, sample valid)
module sample_scheduler
  import rast_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sample_scheduler_if.slave     bus
);

  state_e state_q, state_d;
  // Low while in reset, so readiness stays off until the first clean cycle
  // without putting rst itself on the ready path.
  logic   live_q;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic signed [SIGFIG-1:0] samp_x_q, samp_y_q, ll_x_q, ur_x_q, ur_y_q;

  logic signed [SIGFIG-1:0] step_w;
  logic signed [SIGFIG-1:0] box_ll_x, box_ll_y, box_ur_x, box_ur_y;
  logic signed [SIGFIG-1:0] snap_x, snap_y, nxt_x, nxt_y;
  logic                     last, accept, empty, halt;

  assign halt     = bus.halt_RnnnnH;
  assign step_w   = SIGFIG'(step_of(bus.subSample_RnnnnU, RADIX));
  assign box_ll_x = $signed(bus.box_R14S[0][0]);
  assign box_ll_y = $signed(bus.box_R14S[0][1]);
  assign box_ur_x = $signed(bus.box_R14S[1][0]);
  assign box_ur_y = $signed(bus.box_R14S[1][1]);

  // Clearing the bits below the step rounds toward -inf for signed values.
  assign snap_x = box_ll_x & ~(step_w - SIGFIG'(1));
  assign snap_y = box_ll_y & ~(step_w - SIGFIG'(1));
  assign empty  = (snap_x > box_ur_x) || (snap_y > box_ur_y);

  assign bus.readyTri_R14H = (state_q == WAIT) && !halt && live_q;
  assign accept            = bus.validTri_R14H && bus.readyTri_R14H;

  sample_step #(.SIGFIG(SIGFIG)) u_step (
    .samp_x (samp_x_q),
    .samp_y (samp_y_q),
    .ll_x   (ll_x_q),
    .ur_x   (ur_x_q),
    .ur_y   (ur_y_q),
    .step   (step_w),
    .nxt_x  (nxt_x),
    .nxt_y  (nxt_y),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (accept && !empty) state_d = TEST;
      TEST:    if (!halt && last)    state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT;
      live_q   <= 1'b0;
      tri_q    <= '0;
      color_q  <= '0;
      samp_x_q <= '0;
      samp_y_q <= '0;
      ll_x_q   <= '0;
      ur_x_q   <= '0;
      ur_y_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept && !empty) begin
        // Empty boxes are consumed by the handshake but never latched.
        tri_q    <= bus.tri_R14S;
        color_q  <= bus.color_R14U;
        samp_x_q <= snap_x;
        samp_y_q <= snap_y;
        ll_x_q   <= snap_x;
        ur_x_q   <= box_ur_x;
        ur_y_q   <= box_ur_y;
      end else if (state_q == TEST && !halt && !last) begin
        samp_x_q <= nxt_x;
        samp_y_q <= nxt_y;
      end
    end
  end

  assign bus.validSamp_R16H = (state_q == TEST);
  assign bus.tri_R16S       = tri_q;
  assign bus.color_R16U     = color_q;
  assign bus.sample_R16S    = {samp_y_q, samp_x_q};

endmodule

// File: tb/tb_sample_scheduler.sv
module tb_sample_scheduler;
  localparam int SF = 24;
  localparam int NV = 3;
  localparam int NA = 3;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_scheduler_if #(.SIGFIG(SF), .VERTS(NV), .AXIS(NA), .COLORS(NC)) bus();

  sample_scheduler #(.SIGFIG(SF), .RADIX(10), .VERTS(NV), .AXIS(NA), .COLORS(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  longint qx[$];
  longint qy[$];

  typedef struct {
    longint llx, lly, urx, ury;
    logic [3:0] ss;
    int     n;
    longint fx, fy, lx, ly;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic longint samp(input int i);
    return longint'($signed(bus.sample_R16S[i]));
  endfunction

  // Reference: enumerate grid points inside the box from the pitch rules.
  task automatic build(input longint llx, lly, urx, ury, input logic [3:0] ss);
    longint st, sx, sy;
    qx.delete();
    qy.delete();
    case (ss)
      4'b0100: st = 512;
      4'b0010: st = 256;
      4'b0001: st = 128;
      default: st = 1024;
    endcase
    sx = (llx >= 0) ? (llx / st) * st : -(((-llx) + st - 1) / st) * st;
    sy = (lly >= 0) ? (lly / st) * st : -(((-lly) + st - 1) / st) * st;
    for (longint y = sy; y <= ury; y += st)
      for (longint x = sx; x <= urx; x += st) begin
        qx.push_back(x);
        qy.push_back(y);
      end
  endtask

  task automatic drive_and_check(input longint llx, lly, urx, ury, input logic [3:0] ss,
                                 input int halt_pct, input bit skip_wait,
                                 output int n_valid, output longint fx, fy, lx, ly);
    logic [NV-1:0][NA-1:0][SF-1:0] tv;
    logic [NC-1:0][SF-1:0]         cv;
    int idx, cyc;
    bit h;
    for (int v = 0; v < NV; v++)
      for (int a = 0; a < NA; a++) tv[v][a] = SF'($urandom);
    for (int c = 0; c < NC; c++) cv[c] = SF'($urandom);
    build(llx, lly, urx, ury, ss);
    n_valid = 0; fx = 0; fy = 0; lx = 0; ly = 0;
    if (!skip_wait) @(negedge clk);
    bus.tri_R14S         = tv;
    bus.color_R14U       = cv;
    bus.box_R14S[0][0]   = SF'(llx);
    bus.box_R14S[0][1]   = SF'(lly);
    bus.box_R14S[1][0]   = SF'(urx);
    bus.box_R14S[1][1]   = SF'(ury);
    bus.subSample_RnnnnU = ss;
    bus.halt_RnnnnH      = 1'b0;
    bus.validTri_R14H    = 1'b1;
    chk("ready_offer", bus.readyTri_R14H, 1);
    @(negedge clk);
    bus.validTri_R14H = 1'b0;
    if (qx.size() == 0) begin
      chk("empty_valid", bus.validSamp_R16H, 0);
      chk("empty_ready", bus.readyTri_R14H, 1);
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < qx.size() && cyc < 20000) begin
      chk("samp_valid", bus.validSamp_R16H, 1);
      if (bus.validSamp_R16H !== 1'b1) break;
      chk("samp_x", samp(0), qx[idx]);
      chk("samp_y", samp(1), qy[idx]);
      chk("samp_tri", bus.tri_R16S, tv);
      chk("samp_color", bus.color_R16U, cv);
      chk("busy_ready", bus.readyTri_R14H, 0);
      if (n_valid == 0) begin fx = samp(0); fy = samp(1); end
      lx = samp(0);
      ly = samp(1);
      n_valid++;
      h = ($urandom_range(99) < halt_pct);
      bus.halt_RnnnnH = h;
      @(negedge clk);
      if (!h) idx++;
      cyc++;
    end
    if (cyc >= 20000) chk("walk_timeout", 0, 1);
    bus.halt_RnnnnH = 1'b0;
    #1;
    chk("end_valid", bus.validSamp_R16H, 0);
    chk("end_ready", bus.readyTri_R14H, 1);
  endtask

  vec_t tbl[7];
  int     n;
  longint fx, fy, lx, ly;
  longint ex[7];
  longint ey[7];
  bit     hp[7];

  initial begin
    tbl[0] = '{0, 0, 1024, 1024, 4'b1000, 4, 0, 0, 1024, 1024};
    tbl[1] = '{300, 0, 1023, 0, 4'b0100, 2, 0, 0, 512, 0};
    tbl[2] = '{-100, -100, 300, 0, 4'b0010, 6, -256, -256, 256, 0};
    tbl[3] = '{0, 0, 127, 127, 4'b0001, 1, 0, 0, 0, 0};
    tbl[4] = '{1000, 0, 3000, 0, 4'b0000, 3, 0, 0, 2048, 0};
    tbl[5] = '{8385607, 0, 8388607, 0, 4'b1000, 3, 8385536, 0, 8387584, 0};
    tbl[6] = '{0, 0, 2047, 1024, 4'b1100, 4, 0, 0, 1024, 1024};

    bus.tri_R14S = '0; bus.color_R14U = '0; bus.box_R14S = '0;
    bus.validTri_R14H = 1'b0; bus.subSample_RnnnnU = 4'b1000; bus.halt_RnnnnH = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.readyTri_R14H, 0);
    chk("rst_valid", bus.validSamp_R16H, 0);
    chk("rst_sample", bus.sample_R16S, 0);
    chk("rst_tri", bus.tri_R16S, 0);
    chk("rst_color", bus.color_R16U, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.readyTri_R14H, 1);

    // table-driven boxes, no halt
    for (int i = 0; i < 7; i++) begin
      drive_and_check(tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury, tbl[i].ss, 0, 0, n, fx, fy, lx, ly);
      chk($sformatf("tbl%0d_n", i), n, tbl[i].n);
      chk($sformatf("tbl%0d_fx", i), fx, tbl[i].fx);
      chk($sformatf("tbl%0d_fy", i), fy, tbl[i].fy);
      chk($sformatf("tbl%0d_lx", i), lx, tbl[i].lx);
      chk($sformatf("tbl%0d_ly", i), ly, tbl[i].ly);
    end

    // empty box, then next triangle accepted the following cycle
    drive_and_check(2048, 0, 1024, 0, 4'b1000, 0, 0, n, fx, fy, lx, ly);
    chk("empty_n", n, 0);
    drive_and_check(0, 0, 1024, 0, 4'b1000, 0, 1, n, fx, fy, lx, ly);
    chk("after_empty_n", n, 2);

    // halt in WAIT blocks acceptance
    @(negedge clk);
    bus.box_R14S[0] = '0;
    bus.box_R14S[1][0] = SF'(1024);
    bus.box_R14S[1][1] = SF'(1024);
    bus.subSample_RnnnnU = 4'b1000;
    bus.halt_RnnnnH = 1'b1;
    bus.validTri_R14H = 1'b1;
    #1;
    chk("wait_halt_ready", bus.readyTri_R14H, 0);
    @(negedge clk);
    chk("wait_halt_valid", bus.validSamp_R16H, 0);
    bus.validTri_R14H = 1'b0;
    bus.halt_RnnnnH = 1'b0;

    // halt for 3 cycles on the 2nd sample of the 2x2 box
    ex = '{0, 1024, 1024, 1024, 1024, 0, 1024};
    ey = '{0, 0, 0, 0, 0, 1024, 1024};
    hp = '{0, 1, 1, 1, 0, 0, 0};
    @(negedge clk);
    bus.validTri_R14H = 1'b1;
    @(negedge clk);
    bus.validTri_R14H = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("halt_valid", bus.validSamp_R16H, 1);
      chk("halt_x", samp(0), ex[i]);
      chk("halt_y", samp(1), ey[i]);
      bus.halt_RnnnnH = hp[i];
      @(negedge clk);
    end
    chk("halt_end_valid", bus.validSamp_R16H, 0);
    chk("halt_end_ready", bus.readyTri_R14H, 1);

    // reset during the 3rd sample
    @(negedge clk);
    bus.validTri_R14H = 1'b1;
    @(negedge clk);
    bus.validTri_R14H = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_x", samp(0), 0);
    chk("pre_rst_y", samp(1), 1024);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.validSamp_R16H, 0);
    chk("mid_rst_ready", bus.readyTri_R14H, 0);
    chk("mid_rst_sample", bus.sample_R16S, 0);
    chk("mid_rst_tri", bus.tri_R16S, 0);
    chk("mid_rst_color", bus.color_R16U, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rec_ready", bus.readyTri_R14H, 1);
    chk("rec_valid", bus.validSamp_R16H, 0);
    drive_and_check(2048, 2048, 3072, 2048, 4'b1000, 0, 1, n, fx, fy, lx, ly);
    chk("rec_n", n, 2);
    chk("rec_fx", fx, 2048);
    chk("rec_fy", fy, 2048);

    // randomized triangles with random halt against the reference walk
    for (int t = 0; t < 30; t++) begin
      longint llx, lly, urx, ury;
      logic [3:0] ss;
      ss  = 4'b1000 >> $urandom_range(3);
      llx = longint'($urandom_range(6000)) - 3000;
      lly = longint'($urandom_range(6000)) - 3000;
      urx = llx + longint'($urandom_range(1700)) - 200;
      ury = lly + longint'($urandom_range(1700)) - 200;
      drive_and_check(llx, lly, urx, ury, ss, 30, 0, n, fx, fy, lx, ly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
